// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the sprite/compositing stages
package game_pkg;
  localparam int COL_W = 12;
  localparam int ROW_W = 11;

  typedef struct packed {
    logic [23:0] rgb;
    logic        opaque;
  } layer_t;

  localparam logic [23:0] TRANSPARENT_KEY = 24'h808000;
  localparam logic [23:0] BLACK           = 24'h000000;

  typedef enum logic [1:0] {
    S_BLANK  = 2'd0,
    S_ACTIVE = 2'd1,
    S_REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/coord_delay.sv
// rtl/coord_delay.sv - parameterised shift register aligning {display_en, row, col} with layer data
module coord_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);
  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= data;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign delayed = pipe[DEPTH-1];
endmodule

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - layer priority compositor with per-frame collision reporting
// Collision FSM and hit outputs exist only when PIXEL_COMPOSITOR_COLLISION_EN is defined.
module pixel_compositor
  import game_pkg::*;
#(
  parameter int          COORD_DELAY = 1,
  parameter logic [23:0] BG_DEFAULT  = BLACK,
  parameter int          HIT_MAX     = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [COL_W-1:0] display_col,
  input  logic [ROW_W-1:0] display_row,
  input  logic             display_en,
  input  logic             calc,
  input  logic             bg_en,
  input  logic [23:0]      bg_color,
  input  logic [24:0]      player_color,
  input  logic [24:0]      bullet_color,
  input  logic [24:0]      enemy_color,
  output logic [23:0]      pixel_rgb,
  output logic             pixel_valid,
  output logic [COL_W-1:0] pixel_col,
  output logic [ROW_W-1:0] pixel_row,
  output logic             hit_pulse,
  output logic             player_hit,
  output logic [COL_W-1:0] hit_col,
  output logic [ROW_W-1:0] hit_row,
  output logic [7:0]       hit_count
);
  layer_t player, bullet, enemy;
  assign player = layer_t'(player_color);
  assign bullet = layer_t'(bullet_color);
  assign enemy  = layer_t'(enemy_color);

  logic             valid_d;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;

  coord_delay #(
    .DEPTH(COORD_DELAY),
    .WIDTH(1 + ROW_W + COL_W)
  ) u_coord_delay (
    .clock  (clock),
    .reset  (reset),
    .data   ({display_en, display_row, display_col}),
    .delayed({valid_d, row_d, col_d})
  );

  logic [23:0]      sel, s1_sel;
  logic             s1_valid;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;

  always_comb begin
    sel = bg_en ? bg_color : BG_DEFAULT;
    if (player.opaque)      sel = player.rgb;
    else if (bullet.opaque) sel = bullet.rgb;
    else if (enemy.opaque)  sel = enemy.rgb;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_sel      <= '0;
      s1_valid    <= 1'b0;
      s1_col      <= '0;
      s1_row      <= '0;
      pixel_rgb   <= '0;
      pixel_valid <= 1'b0;
      pixel_col   <= '0;
      pixel_row   <= '0;
    end else begin
      s1_sel      <= sel;
      s1_valid    <= valid_d;
      s1_col      <= col_d;
      s1_row      <= row_d;
      pixel_rgb   <= s1_valid ? s1_sel : 24'h000000;
      pixel_valid <= s1_valid;
      pixel_col   <= s1_col;
      pixel_row   <= s1_row;
    end
  end

`ifdef PIXEL_COMPOSITOR_COLLISION_EN
  state_t state, state_next;
  logic   calc_q, bhit, phit, sample;

  always_ff @(posedge clock) begin
    if (reset) state <= S_BLANK;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sample     = (state == S_ACTIVE) && valid_d && !calc;
    case (state)
      S_BLANK:  if (!calc) state_next = S_ACTIVE;
      S_ACTIVE: if (calc && !calc_q) state_next = S_REPORT;
      S_REPORT: state_next = calc ? S_BLANK : S_ACTIVE;
      default:  state_next = S_BLANK;
    endcase
  end

  // calc_q resets high so a calc already high at reset release is not a rising edge
  always_ff @(posedge clock) begin
    if (reset) begin
      calc_q     <= 1'b1;
      bhit       <= 1'b0;
      phit       <= 1'b0;
      hit_pulse  <= 1'b0;
      player_hit <= 1'b0;
      hit_col    <= '0;
      hit_row    <= '0;
      hit_count  <= '0;
    end else begin
      calc_q     <= calc;
      hit_pulse  <= (state == S_REPORT) && bhit;
      player_hit <= (state == S_REPORT) && phit;
      if (state == S_REPORT) begin
        bhit <= 1'b0;
        phit <= 1'b0;
        if (bhit && (hit_count != HIT_MAX[7:0])) hit_count <= hit_count + 8'd1;
      end else if (sample) begin
        if (bullet.opaque && enemy.opaque) begin
          bhit <= 1'b1;
          if (!bhit) begin
            hit_col <= col_d;
            hit_row <= row_d;
          end
        end
        if (player.opaque && enemy.opaque) phit <= 1'b1;
      end
    end
  end
`else
  logic unused_calc;
  assign unused_calc = calc | (HIT_MAX == 0);
  assign hit_pulse   = 1'b0;
  assign player_hit  = 1'b0;
  assign hit_col     = '0;
  assign hit_row     = '0;
  assign hit_count   = '0;
`endif
endmodule

// File: tb/tb_pixel_compositor.sv
// tb/tb_pixel_compositor.sv - scoreboard bench for pixel_compositor compositing and collision reports
module tb_pixel_compositor;
`ifdef PIXEL_COMPOSITOR_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] display_col = '0;
  logic [10:0] display_row = '0;
  logic        display_en = 1'b0;
  logic        calc = 1'b1;
  logic        bg_en = 1'b0;
  logic [23:0] bg_color = '0;
  logic [24:0] player_color = '0, bullet_color = '0, enemy_color = '0;
  logic [23:0] pixel_rgb;
  logic        pixel_valid;
  logic [11:0] pixel_col;
  logic [10:0] pixel_row;
  logic        hit_pulse, player_hit;
  logic [11:0] hit_col;
  logic [10:0] hit_row;
  logic [7:0]  hit_count;

  pixel_compositor dut (
    .clock(clock), .reset(reset),
    .display_col(display_col), .display_row(display_row), .display_en(display_en),
    .calc(calc), .bg_en(bg_en), .bg_color(bg_color),
    .player_color(player_color), .bullet_color(bullet_color), .enemy_color(enemy_color),
    .pixel_rgb(pixel_rgb), .pixel_valid(pixel_valid), .pixel_col(pixel_col), .pixel_row(pixel_row),
    .hit_pulse(hit_pulse), .player_hit(player_hit), .hit_col(hit_col), .hit_row(hit_row),
    .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        valid;
    logic [11:0] col;
    logic [10:0] row;
    logic [23:0] rgb;
  } pix_exp_t;

  typedef struct {
    logic        hp;
    logic        ph;
    logic [11:0] col;
    logic [10:0] row;
    logic [7:0]  cnt;
  } hit_exp_t;

  pix_exp_t pq[$];
  hit_exp_t hq[$];
  pix_exp_t pe;
  hit_exp_t he;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [24:0] op(input logic [23:0] rgb);
    return {rgb, 1'b1};
  endfunction

  // Layers lag coordinates by one cycle, so each call drives the previous pixel's layers.
  logic [24:0] p_pl = '0, p_bu = '0, p_em = '0;
  logic        p_bge = 1'b0, p_valid = 1'b0, p_have = 1'b0;
  logic [23:0] p_bg = '0, p_rgb = '0;
  logic [11:0] p_col = '0;
  logic [10:0] p_row = '0;
  logic        calc_next = 1'b1;

  task automatic pix(input logic v, input logic [11:0] c, input logic [10:0] r,
                     input logic [24:0] pl, input logic [24:0] bu, input logic [24:0] em,
                     input logic bge, input logic [23:0] bg, input logic [23:0] ex);
    @(posedge clock); #1;
    display_en   = v;
    display_col  = c;
    display_row  = r;
    player_color = p_pl;
    bullet_color = p_bu;
    enemy_color  = p_em;
    bg_en        = p_bge;
    bg_color     = p_bg;
    calc         = calc_next;
    if (p_have) pq.push_back('{cyc + 2, p_valid, p_col, p_row, p_rgb});
    p_pl = pl; p_bu = bu; p_em = em; p_bge = bge; p_bg = bg;
    p_valid = v; p_col = c; p_row = r; p_rgb = ex; p_have = 1'b1;
  endtask

  task automatic flush();
    pix(1'b0, 12'd0, 11'd0, '0, '0, '0, 1'b0, 24'h0, 24'h0);
  endtask

  task automatic set_calc(input logic v);
    @(posedge clock); #1;
    calc      = v;
    calc_next = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_hit(input logic hp, input logic ph, input logic [11:0] c,
                            input logic [10:0] r, input logic [7:0] n);
    if (COLL) hq.push_back('{hp, ph, c, r, n});
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        pe = pq.pop_front();
        check("pixel_timing", cyc, pe.due);
        check("pixel_valid", pixel_valid, pe.valid);
        check("pixel_rgb", pixel_rgb, pe.rgb);
        check("pixel_col", pixel_col, pe.col);
        check("pixel_row", pixel_row, pe.row);
      end
      if (hit_pulse === 1'b1 || player_hit === 1'b1) begin
        if (hq.size() == 0) begin
          check("unexpected_hit_report", {hit_pulse, player_hit}, 2'b00);
        end else begin
          he = hq.pop_front();
          check("hit_pulse", hit_pulse, he.hp);
          check("player_hit", player_hit, he.ph);
          check("hit_col", hit_col, he.col);
          check("hit_row", hit_row, he.row);
          check("hit_count", hit_count, he.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    idle(3);
    reset = 1'b0;
    idle(1);
    check("reset_pixel_rgb", pixel_rgb, 24'h0);
    check("reset_pixel_valid", pixel_valid, 1'b0);
    check("reset_hit_count", hit_count, 8'd0);
    check("reset_hit_col", hit_col, 12'd0);

    // Priority and transparency while calc is high (no collision sampling)
    pix(1'b1, 12'd1, 11'd1, {24'hAAAAAA, 1'b0}, {24'h55AA55, 1'b0}, {24'h123456, 1'b0}, 1'b0, 24'h123456, 24'h000000);
    pix(1'b1, 12'd2, 11'd1, op(24'hFF0000), op(24'h00FF00), '0, 1'b1, 24'h0000FF, 24'hFF0000);
    pix(1'b1, 12'd3, 11'd1, {24'hFF0000, 1'b0}, op(24'h00FF00), '0, 1'b1, 24'h0000FF, 24'h00FF00);
    pix(1'b1, 12'd4, 11'd1, {24'hFF0000, 1'b0}, {24'h00FF00, 1'b0}, '0, 1'b1, 24'h0000FF, 24'h0000FF);
    pix(1'b1, 12'd5, 11'd1, '0, '0, op(24'hC0FFEE), 1'b1, 24'h0000FF, 24'hC0FFEE);
    pix(1'b0, 12'd6, 11'd1, '0, op(24'h00FF00), '0, 1'b0, 24'h0, 24'h000000);
    pix(1'b1, 12'd4095, 11'd2047, '0, '0, '0, 1'b1, 24'hABCDEF, 24'hABCDEF);
    flush(); flush();

    // Frame with two bullet/enemy overlaps and one player/enemy overlap
    set_calc(1'b0);
    pix(1'b1, 12'd100, 11'd50, '0, op(24'h00FF00), op(24'h0000FF), 1'b0, 24'h0, 24'h00FF00);
    pix(1'b1, 12'd200, 11'd60, '0, op(24'h00FF00), op(24'h0000FF), 1'b0, 24'h0, 24'h00FF00);
    pix(1'b1, 12'd150, 11'd55, op(24'hFF0000), '0, op(24'h0000FF), 1'b0, 24'h0, 24'hFF0000);
    flush(); flush();
    expect_hit(1'b1, 1'b1, 12'd100, 11'd50, 8'd1);
    set_calc(1'b1);
    idle(4);

    // Frame without overlap: no report, capture held
    set_calc(1'b0);
    pix(1'b1, 12'd120, 11'd40, '0, op(24'h00FF00), '0, 1'b0, 24'h0, 24'h00FF00);
    pix(1'b1, 12'd121, 11'd40, '0, '0, op(24'h0000FF), 1'b0, 24'h0, 24'h0000FF);
    flush(); flush();
    set_calc(1'b1);
    idle(4);
    check("held_count", hit_count, COLL ? 8'd1 : 8'd0);
    check("held_col", hit_col, COLL ? 12'd100 : 12'd0);
    check("held_row", hit_row, COLL ? 11'd50 : 11'd0);

    // Overlap arriving on the calc rising-edge cycle is ignored
    set_calc(1'b0);
    pix(1'b1, 12'd10, 11'd10, '0, op(24'h00FF00), op(24'h0000FF), 1'b0, 24'h0, 24'h00FF00);
    calc_next = 1'b1;
    flush(); flush();
    idle(4);
    check("edge_ignored_count", hit_count, COLL ? 8'd1 : 8'd0);

    // 300 hit frames saturate the counter
    for (int k = 0; k < 300; k++) begin
      set_calc(1'b0);
      pix(1'b1, 12'd300, 11'd70, '0, op(24'h00FF00), op(24'h0000FF), 1'b0, 24'h0, 24'h00FF00);
      flush(); flush();
      expect_hit(1'b1, 1'b0, 12'd300, 11'd70, (k + 2 > 255) ? 8'd255 : 8'(k + 2));
      set_calc(1'b1);
      idle(2);
    end
    idle(3);
    check("saturated_count", hit_count, COLL ? 8'd255 : 8'd0);
    check("saturated_col", hit_col, COLL ? 12'd300 : 12'd0);

    // Reset mid-frame discards the pending hit
    set_calc(1'b0);
    pix(1'b1, 12'd400, 11'd80, '0, op(24'h00FF00), op(24'h0000FF), 1'b0, 24'h0, 24'h00FF00);
    flush(); flush();
    idle(3);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    set_calc(1'b1);
    idle(4);
    check("post_reset_count", hit_count, 8'd0);
    check("post_reset_col", hit_col, 12'd0);
    check("post_reset_row", hit_row, 11'd0);
    check("post_reset_valid", pixel_valid, 1'b0);

    idle(5);
    check("pixel_queue_drained", pq.size(), 0);
    check("hit_queue_drained", hq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
